// File: rtl/ofifo_col_collector.sv
// ofifo_col_collector
//   De-skew buffer for the bottom row of a systolic MAC array. Each column
//   owns a circular FIFO that is written independently whenever that column's
//   valid strobe fires; because columns arrive one cycle apart, a full aligned
//   row is only available once every column FIFO holds at least one entry.
//   A pop removes one entry from every column at once and registers the
//   resulting row on `out`.
//
//   Optional feature macro: OFIFO_RELU_EN
//     defined   -> each popped lane is ReLU'd (negative psums become 0);
//                  FIFO contents stay raw.
//     undefined -> popped lanes are passed bit-exact.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pointers, counts, out, flags
//   in         psum bus, column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr         per-column write strobe
//   rd         pop one aligned row (ignored while o_ready is low)
//   out        registered popped row, same packing as `in`
//   out_valid  one-cycle pulse when `out` was updated by a pop
//   o_ready    every column FIFO non-empty
//   o_full     any column FIFO full
//   o_ovf      sticky: a write was dropped on a full column

module ofifo_col_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_ovf
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    // NOTE: the data array has no reset; only pointers and counts are cleared,
    // which is enough to make stale entries unreachable and keeps the array
    // mappable onto plain RAM.
    logic [psum_bw-1:0] mem_q [col][depth];

    logic [AW-1:0]          wptr_q  [col];
    logic [AW-1:0]          wptr_d  [col];
    logic [CW-1:0]          count_q [col];
    logic [CW-1:0]          count_d [col];
    // All columns pop together, so one read pointer serves every column.
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ovf_q, ovf_d;

    logic                   pop;
    logic [col-1:0]         accept;

    function automatic logic [psum_bw-1:0] pop_lane(input logic [psum_bw-1:0] v);
`ifdef OFIFO_RELU_EN
        return v[psum_bw-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Status flags come only from registered counts: no input-to-output path.
    always_comb begin
        o_ready = 1'b1;
        o_full  = 1'b0;
        for (int c = 0; c < col; c++) begin
            if (count_q[c] == '0)         o_ready = 1'b0;
            if (count_q[c] == CW'(depth)) o_full  = 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pop         = rd && o_ready;
        rptr_d      = rptr_q + AW'(pop);
        out_d       = out_q;
        out_valid_d = pop;
        ovf_d       = ovf_q;
        accept      = '0;
        for (int c = 0; c < col; c++) begin
            // A full column can still take a write when the pop frees the slot.
            accept[c]  = wr[c] && ((count_q[c] != CW'(depth)) || pop);
            wptr_d[c]  = wptr_q[c] + AW'(accept[c]);
            count_d[c] = count_q[c] + CW'(accept[c]) - CW'(pop);
            if (wr[c] && !accept[c]) ovf_d = 1'b1;
            if (pop) out_d[c*psum_bw +: psum_bw] = pop_lane(mem_q[c][rptr_q]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int c = 0; c < col; c++) begin
                wptr_q[c]  <= '0;
                count_q[c] <= '0;
            end
        end else begin
            rptr_q      <= rptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            for (int c = 0; c < col; c++) begin
                wptr_q[c]  <= wptr_d[c];
                count_q[c] <= count_d[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (accept[c] && !reset) mem_q[c][wptr_q[c]] <= in[c*psum_bw +: psum_bw];
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_ofifo_col_collector.sv
// tb_ofifo_col_collector
//   Self-checking bench for ofifo_col_collector. A queue-per-column reference
//   model tracks expected contents; every cycle all outputs are compared
//   against it, plus directed checks at the notable points of each scenario.

module tb_ofifo_col_collector;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [BW*COL-1:0]   in_bus;
    logic [COL-1:0]      wr;
    logic                rd;
    logic [BW*COL-1:0]   out_bus;
    logic                out_valid, o_ready, o_full, o_ovf;

    ofifo_col_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_bus),
        .wr        (wr),
        .rd        (rd),
        .out       (out_bus),
        .out_valid (out_valid),
        .o_ready   (o_ready),
        .o_full    (o_full),
        .o_ovf     (o_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [BW-1:0]     mq [COL][$];
    logic [BW*COL-1:0] exp_out   = '0;
    logic              exp_valid = 1'b0;
    logic              exp_ovf   = 1'b0;

    function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef OFIFO_RELU_EN
        return v[BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [BW*COL-1:0] obs,
                         input logic [BW*COL-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // One clock: update the model from the inputs present at the edge, then
    // compare every output 1 ns later.
    task automatic cycle();
        bit pop;
        int sz [COL];
        logic ready_e, full_e;
        pop = rd;
        for (int c = 0; c < COL; c++) begin
            sz[c] = mq[c].size();
            if (sz[c] == 0) pop = 0;
        end
        @(posedge clk);
        if (reset) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            exp_out   = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            exp_valid = pop;
            if (pop)
                for (int c = 0; c < COL; c++) exp_out[c*BW +: BW] = relu(mq[c].pop_front());
            for (int c = 0; c < COL; c++) begin
                if (wr[c]) begin
                    if (sz[c] < DEPTH || pop) mq[c].push_back(in_bus[c*BW +: BW]);
                    else exp_ovf = 1'b1;
                end
            end
        end
        ready_e = 1'b1;
        full_e  = 1'b0;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == 0)     ready_e = 1'b0;
            if (mq[c].size() == DEPTH) full_e  = 1'b1;
        end
        #1;
        check("out", out_bus, exp_out);
        check("out_valid", {127'b0, out_valid}, {127'b0, exp_valid});
        check("o_ready", {127'b0, o_ready}, {127'b0, ready_e});
        check("o_full", {127'b0, o_full}, {127'b0, full_e});
        check("o_ovf", {127'b0, o_ovf}, {127'b0, exp_ovf});
    endtask

    function automatic logic [BW*COL-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        reset = 1'b1; wr = '1; rd = 1'b1; in_bus = rnd_row();
        cycle();
        cycle();
        reset = 1'b0; wr = '0; rd = 1'b0;
    endtask

    initial begin
        logic [BW*COL-1:0] row;
        reset = 1'b1; wr = '1; rd = 1'b0; in_bus = '0;

        // 1: reset held two cycles with all write strobes high.
        do_reset();
        check("reset_out", out_bus, '0);
        check("reset_ready", {127'b0, o_ready}, 128'd0);

        // 2: skewed fill, column c at cycle c.
        for (int c = 0; c < COL; c++) begin
            wr = '0; wr[c] = 1'b1;
            in_bus = rnd_row();
            in_bus[c*BW +: BW] = BW'(16*c + 1);
            cycle();
            if (c < COL - 1) check("skew_not_ready", {127'b0, o_ready}, 128'd0);
        end
        wr = '0;
        check("skew_ready", {127'b0, o_ready}, 128'd1);
        rd = 1'b1;
        cycle();
        rd = 1'b0;
        check("skew_valid", {127'b0, out_valid}, 128'd1);
        for (int c = 0; c < COL; c++)
            check($sformatf("skew_lane%0d", c), {112'b0, out_bus[c*BW +: BW]}, 128'(16*c + 1));

        // 3: fill to full, overflow on column 3, drain, extra rd ignored.
        wr = '1;
        for (int i = 0; i < DEPTH; i++) begin
            in_bus = rnd_row();
            cycle();
        end
        check("full_after_64", {127'b0, o_full}, 128'd1);
        wr = 8'h08; in_bus = rnd_row();
        cycle();
        check("ovf_col3", {127'b0, o_ovf}, 128'd1);
        wr = '0; rd = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        cycle();
        check("rd_empty_ignored", {127'b0, out_valid}, 128'd0);
        rd = 1'b0;

        // 4: full FIFO with simultaneous pop and write of 0x00AA.
        do_reset();
        wr = '1;
        for (int i = 0; i < DEPTH; i++) begin
            in_bus = rnd_row();
            cycle();
        end
        rd = 1'b1;
        in_bus = {COL{16'h00AA}};
        cycle();
        check("full_rw_ovf", {127'b0, o_ovf}, 128'd0);
        check("full_rw_full", {127'b0, o_full}, 128'd1);
        wr = '0;
        for (int i = 0; i < DEPTH; i++) cycle();
        rd = 1'b0;
        check("full_rw_last", out_bus, {COL{16'h00AA}});

        // 5: 200-row stream with rd held high, reset at row 100.
        do_reset();
        wr = '1; rd = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_bus = rnd_row();
            reset = (i == 100);
            cycle();
            if (i == 100) begin
                check("stream_rst_ready", {127'b0, o_ready}, 128'd0);
                check("stream_rst_valid", {127'b0, out_valid}, 128'd0);
            end
        end
        reset = 1'b0; wr = '0;
        for (int i = 0; i < 4; i++) cycle();
        check("stream_drained", {127'b0, o_ready}, 128'd0);
        rd = 1'b0;

        // 6: ReLU on the pop path.
        do_reset();
        row = rnd_row();
        row[0 +: BW]  = 16'hFFF0;
        row[BW +: BW] = 16'h0010;
        in_bus = row; wr = '1;
        cycle();
        wr = '0; rd = 1'b1;
        cycle();
        rd = 1'b0;
`ifdef OFIFO_RELU_EN
        check("relu_lane0", {112'b0, out_bus[0 +: BW]}, 128'h0000);
`else
        check("relu_lane0", {112'b0, out_bus[0 +: BW]}, 128'hFFF0);
`endif
        check("relu_lane1", {112'b0, out_bus[BW +: BW]}, 128'h0010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
